// File: rtl/board_vram_writer.sv
// Sole writer of the board VRAM: turns clear/place commands
// into a stream of single-cell writes on the VRAM write port.
module board_vram_writer #(
  parameter int BOARD_W   = 14,
  parameter int BOARD_H   = 14,
  parameter int CELL_BITS = 6,
  parameter int ADDR_W    = 8,
  parameter int SHAPE_N   = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic                         cmd_op,
  input  logic [3:0]                   cmd_x,
  input  logic [3:0]                   cmd_y,
  input  logic [CELL_BITS-1:0]         cmd_color,
  input  logic [SHAPE_N*SHAPE_N-1:0]   cmd_shape,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic [CELL_BITS-1:0]         wr_data,
  output logic                         wr_en,
  output logic                         done,
  output logic [7:0]                   wr_count
);

  localparam int SN2 = SHAPE_N * SHAPE_N;
  localparam int CELLS = BOARD_W * BOARD_H;
  localparam logic [ADDR_W:0] CLR_END = (ADDR_W+1)'(CELLS);
  localparam logic [4:0] COL_LIM = 5'(BOARD_W);
  localparam logic [4:0] ROW_LIM = 5'(BOARD_H);
  localparam logic [2:0] DX_LAST = 3'(SHAPE_N - 1);
  localparam logic [2:0] DY_END  = 3'(SHAPE_N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_PLACE,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W:0]       cnt_q, cnt_d;
  logic [2:0]            dx_q, dx_d;
  logic [2:0]            dy_q, dy_d;
  logic [3:0]            x_q, x_d;
  logic [3:0]            y_q, y_d;
  logic [CELL_BITS-1:0]  color_q, color_d;
  logic [SN2-1:0]        shape_q, shape_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [CELL_BITS-1:0]  wr_data_q, wr_data_d;
  logic                  wr_en_q, wr_en_d;
  logic                  done_q, done_d;
  logic [7:0]            wr_count_q, wr_count_d;

  logic [4:0]            col;
  logic [4:0]            row;
  logic [ADDR_W-1:0]     cell_addr;
  logic                  hit;

  // Board cell addressed by the current scan position; 5-bit sums avoid wrap.
  assign col = {1'b0, x_q} + {2'b00, dx_q};
  assign row = {1'b0, y_q} + {2'b00, dy_q};
  assign cell_addr = ADDR_W'(row) * ADDR_W'(BOARD_W) + ADDR_W'(col);
  assign hit = shape_q[0] && (col < COL_LIM) && (row < ROW_LIM);

  assign cmd_ready = (state_q == S_IDLE);
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_en     = wr_en_q;
  assign done      = done_q;
  assign wr_count  = wr_count_q;

  // Next-state and registered-output computation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    x_d        = x_q;
    y_d        = y_q;
    color_d    = color_q;
    shape_d    = shape_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    done_d     = 1'b0;
    wr_count_d = wr_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          x_d        = cmd_x;
          y_d        = cmd_y;
          color_d    = cmd_color;
          shape_d    = cmd_shape;
          cnt_d      = '0;
          dx_d       = '0;
          dy_d       = '0;
          wr_count_d = '0;
          state_d    = cmd_op ? S_CLEAR : S_PLACE;
        end
      end
      S_CLEAR: begin
        if (cnt_q == CLR_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          wr_data_d = '0;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      S_PLACE: begin
        if (dy_q == DY_END) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          if (hit) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cell_addr;
            wr_data_d = color_q;
          end
          shape_d = shape_q >> 1;
          if (dx_q == DX_LAST) begin
            dx_d = '0;
            dy_d = dy_q + 3'd1;
          end else begin
            dx_d = dx_q + 3'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase
    if (wr_en_d) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  // State and output registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      shape_q    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      done_q     <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      shape_q    <= shape_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      done_q     <= done_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_board_vram_writer.sv
// Bench for board_vram_writer: directed cases plus random
// placements checked against a cell-list reference model.
module tb_board_vram_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_op;
  logic [3:0]  cmd_x;
  logic [3:0]  cmd_y;
  logic [5:0]  cmd_color;
  logic [24:0] cmd_shape;
  logic [7:0]  wr_addr;
  logic [5:0]  wr_data;
  logic        wr_en;
  logic        done;
  logic [7:0]  wr_count;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int obs_q[$];
  int done_at[$];
  int cnt_at[$];

  board_vram_writer dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_color (cmd_color),
    .cmd_shape (cmd_shape),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .done      (done),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: the list of (addr,data) writes a command must produce.
  task automatic model(input bit op, input int x, input int y,
                       input int color, input logic [24:0] shape,
                       output int lat);
    if (op) begin
      for (int a = 0; a < 196; a++) exp_q.push_back(a * 64);
      lat = 197;
    end else begin
      for (int k = 0; k < 25; k++) begin
        int col;
        int row;
        col = x + (k % 5);
        row = y + (k / 5);
        if (shape[k] && col < 14 && row < 14)
          exp_q.push_back((row * 14 + col) * 64 + color);
      end
      lat = 26;
    end
  endtask

  task automatic send(input bit op, input int x, input int y,
                      input int color, input logic [24:0] shape,
                      input bit keep);
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_op    = op;
    cmd_x     = 4'(x);
    cmd_y     = 4'(y);
    cmd_color = 6'(color);
    cmd_shape = shape;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!keep) begin
      cmd_valid = 1'b0;
      cmd_x     = 4'($urandom);
      cmd_y     = 4'($urandom);
      cmd_color = 6'($urandom);
      cmd_shape = 25'($urandom);
      cmd_op    = 1'($urandom);
    end
  endtask

  // Sample index n = outputs registered at the n-th edge after accept.
  task automatic collect(input int want, input int max_cyc);
    obs_q.delete();
    done_at.delete();
    cnt_at.delete();
    for (int n = 0; n <= max_cyc; n++) begin
      @(negedge clk);
      if (wr_en) obs_q.push_back(int'(wr_addr) * 64 + int'(wr_data));
      if (done) begin
        done_at.push_back(n);
        cnt_at.push_back(int'(wr_count));
        check("ready_in_done", cmd_ready, 0);
        check("wren_in_done", wr_en, 0);
      end
      if (done_at.size() == want) break;
    end
    check("done_seen", done_at.size(), want);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("ready_after", cmd_ready, 1);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_nwr"}, obs_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      if (i < obs_q.size()) check({tag, "_wr"}, obs_q[i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  task automatic run_one(input string tag, input bit op,
                         input int x, input int y, input int color,
                         input logic [24:0] shape);
    int lat;
    int nexp;
    model(op, x, y, color, shape, lat);
    nexp = exp_q.size();
    send(op, x, y, color, shape, 1'b0);
    collect(1, lat + 10);
    compare_writes(tag);
    if (done_at.size() > 0) begin
      check({tag, "_lat"}, done_at[0], lat);
      check({tag, "_cnt"}, cnt_at[0], nexp);
    end
  endtask

  initial begin
    int lat1;
    int lat2;
    int n1;
    int n2;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_color = '0;
    cmd_shape = '0;
    #12;
    check("rst_ready", cmd_ready, 1);
    check("rst_wren", wr_en, 0);
    check("rst_done", done, 0);
    check("rst_count", wr_count, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    @(negedge clk);
    rst = 1'b0;

    run_one("clear", 1'b1, 0, 0, 0, 25'h0);
    run_one("one", 1'b0, 0, 0, 6'h15, 25'h1);
    run_one("corner", 1'b0, 12, 12, 6'h2A, 25'h1FFFFFF);
    run_one("offboard", 1'b0, 15, 3, 6'h3F, 25'h1FFFFFF);

    // Two commands with cmd_valid held high throughout.
    model(1'b0, 2, 4, 6'h07, 25'h0A5A5A5, lat1);
    n1 = exp_q.size();
    model(1'b0, 11, 9, 6'h31, 25'h1F0F0F1, lat2);
    n2 = exp_q.size() - n1;
    send(1'b0, 2, 4, 6'h07, 25'h0A5A5A5, 1'b1);
    cmd_x     = 4'd11;
    cmd_y     = 4'd9;
    cmd_color = 6'h31;
    cmd_shape = 25'h1F0F0F1;
    fork
      collect(2, lat1 + lat2 + 20);
      begin
        repeat (lat1 + 2) @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
    join
    compare_writes("b2b");
    if (done_at.size() == 2) begin
      check("b2b_lat1", done_at[0], lat1);
      check("b2b_lat2", done_at[1], lat1 + 2 + lat2);
      check("b2b_cnt1", cnt_at[0], n1);
      check("b2b_cnt2", cnt_at[1], n2);
    end

    // Reset during a clear after 50 writes.
    send(1'b1, 0, 0, 0, 25'h0, 1'b0);
    obs_q.delete();
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      if (wr_en) obs_q.push_back(int'(wr_addr) * 64 + int'(wr_data));
    end
    rst = 1'b1;
    #1;
    check("abort_wren", wr_en, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_done", done, 0);
    for (int a = 0; a < 50; a++) exp_q.push_back(a * 64);
    compare_writes("abort");
    @(negedge clk);
    rst = 1'b0;
    run_one("post_rst", 1'b0, 5, 6, 6'h12, 25'h0477C44);

    // Random traffic.
    repeat (30) begin
      bit op;
      op = ($urandom_range(0, 9) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_one("rand", op, int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)),
              int'($urandom_range(0, 63)), 25'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
